// File: rtl/tawas_load_retire_pkg.sv
// -----------------------------------------------------------------------------
// tawas_load_retire_pkg
// Shared constants and types for the Tawas load retire stage:
//   SLICE_CNT  number of hardware thread slices (4)
//   SLICE_W    width of a slice index (2)
//   SEL_W      width of a register-select field (3)
//   DATA_W     width of a register value (32)
//   ENTRY_W    width of one buffered result {sel, data}
// -----------------------------------------------------------------------------
package tawas_load_retire_pkg;

  localparam int SLICE_CNT = 4;
  localparam int SLICE_W   = 2;
  localparam int SEL_W     = 3;
  localparam int DATA_W    = 32;
  localparam int ENTRY_W   = SEL_W + DATA_W;

  // One buffered load/exchange result; sel sits in the top bits.
  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } retire_entry_t;

endpackage

// File: rtl/tawas_retire_fifo.sv
// -----------------------------------------------------------------------------
// tawas_retire_fifo
// Single-slice synchronous FIFO holding pending retire results.
// Pointers carry an extra wrap bit so full and empty fall out of a compare.
// A push into a full FIFO is ignored (the caller flags the overflow).
// Storage is intentionally not reset; only the pointers are.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   push, pop    enqueue din / dequeue head
//   din, dout    entry in / head entry out
//   empty, full  occupancy flags
// -----------------------------------------------------------------------------
module tawas_retire_fifo
  import tawas_load_retire_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout,
  output logic               empty,
  output logic               full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]      wr_ptr_r;
  logic [PW-1:0]      rd_ptr_r;
  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic               wr_en_s;
  logic               rd_en_s;

  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign wr_en_s = push && !full;
  assign rd_en_s = pop && !empty;
  assign dout    = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update with reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  // Entry storage, written on accepted push only.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/tawas_load_retire.sv
// -----------------------------------------------------------------------------
// tawas_load_retire
// Write-back retire stage behind the Tawas RCN bus interface. Results are
// buffered per thread slice and written into the register file during that
// slice's own write-back slot, whenever the core is not using the write port.
// The owning thread is held stalled until its result is architecturally written.
//
// Optional feature macro: TAWAS_LOAD_RETIRE_BYPASS_EN
//   When defined, a result arriving in its own slot with an empty FIFO and a
//   free write port goes straight to the write register (1-cycle latency).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   slice               slice currently in write-back (rotates 0..3)
//   core_wb_vld         core owns the register file write port this cycle
//   rcn_load_vld/_slice/_sel/rcn_load   incoming result
//   rf_wr/_slice/_sel/_data             registered register file write
//   retire_stall        per-slice stall (combinational)
//   overflow            sticky: a result was dropped into a full FIFO
// -----------------------------------------------------------------------------
module tawas_load_retire
  import tawas_load_retire_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SLICE_W-1:0]   slice,
  input  logic                 core_wb_vld,
  input  logic                 rcn_load_vld,
  input  logic [SLICE_W-1:0]   rcn_load_slice,
  input  logic [SEL_W-1:0]     rcn_load_sel,
  input  logic [DATA_W-1:0]    rcn_load,
  output logic                 rf_wr,
  output logic [SLICE_W-1:0]   rf_wr_slice,
  output logic [SEL_W-1:0]     rf_wr_sel,
  output logic [DATA_W-1:0]    rf_wr_data,
  output logic [SLICE_CNT-1:0] retire_stall,
  output logic                 overflow
);

  logic [SLICE_CNT-1:0] arrive_s;
  logic [SLICE_CNT-1:0] push_s;
  logic [SLICE_CNT-1:0] pop_s;
  logic [SLICE_CNT-1:0] empty_s;
  logic [SLICE_CNT-1:0] full_s;
  logic [ENTRY_W-1:0]   dout_s [SLICE_CNT];
  logic                 bypass_s;
  retire_entry_t        load_ent_s;
  retire_entry_t        head_s;

  assign load_ent_s = {rcn_load_sel, rcn_load};

  // Decode which slice the incoming result belongs to.
  always_comb begin
    arrive_s = {SLICE_CNT{1'b0}};
    for (int s = 0; s < SLICE_CNT; s++) begin
      arrive_s[s] = rcn_load_vld && (rcn_load_slice == SLICE_W'(s));
    end
  end

  // Bypass decision: only when the result lands in its own free slot.
  always_comb begin
`ifdef TAWAS_LOAD_RETIRE_BYPASS_EN
    bypass_s = rcn_load_vld && (rcn_load_slice == slice) &&
               empty_s[slice] && !core_wb_vld;
`else
    bypass_s = 1'b0;
`endif
  end

  // A bypassed result is never also enqueued.
  assign push_s = arrive_s & {SLICE_CNT{~bypass_s}};

  // Only the slice in write-back may pop, so at most one pop per cycle.
  always_comb begin
    pop_s = {SLICE_CNT{1'b0}};
    for (int s = 0; s < SLICE_CNT; s++) begin
      pop_s[s] = (slice == SLICE_W'(s)) && !empty_s[s] && !core_wb_vld;
    end
  end

  // Head entry of the FIFO owned by the slice in write-back.
  always_comb begin
    head_s = retire_entry_t'(dout_s[slice]);
  end

  generate
    for (genvar g = 0; g < SLICE_CNT; g++) begin : g_fifo
      tawas_retire_fifo #(
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s[g]),
        .pop   (pop_s[g]),
        .din   (load_ent_s),
        .dout  (dout_s[g]),
        .empty (empty_s[g]),
        .full  (full_s[g])
      );
    end
  endgenerate

  // Registered register file write; fields hold when no write occurs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr       <= 1'b0;
      rf_wr_slice <= {SLICE_W{1'b0}};
      rf_wr_sel   <= {SEL_W{1'b0}};
      rf_wr_data  <= {DATA_W{1'b0}};
    end else if (bypass_s) begin
      rf_wr       <= 1'b1;
      rf_wr_slice <= slice;
      rf_wr_sel   <= rcn_load_sel;
      rf_wr_data  <= rcn_load;
    end else if (|pop_s) begin
      rf_wr       <= 1'b1;
      rf_wr_slice <= slice;
      rf_wr_sel   <= head_s.sel;
      rf_wr_data  <= head_s.data;
    end else begin
      rf_wr       <= 1'b0;
    end
  end

  // Sticky overflow: a push reached a FIFO that was already full.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (|(push_s & full_s)) begin
      overflow <= 1'b1;
    end
  end

  // Stall covers the arrival cycle too, so there is no gap after the RCN stall.
  assign retire_stall = ~empty_s | arrive_s;

endmodule

// File: doc/tawas_load_retire.md
Name: tawas_load_retire

Overview:
Write-back retire stage directly downstream of the Tawas RCN bus interface. Accepts RCN load/exchange results (valid, slice, register select, data) and buffers them per thread slice. Writes each result into the register file during that slice's own write-back slot, only when the core pipeline is not using the write port. Holds the issuing thread stalled until its load data is architecturally written.

Parameters:
DEPTH, 2, entries per slice FIFO (power of two, 2..8)

Ports:
clk  in  1  core clock; all state on rising edge
rst  in  1  synchronous, active-high reset
slice  in  2  thread slice currently in the write-back stage (rotates 0,1,2,3,0...)
core_wb_vld  in  1  core pipeline writes the register file this cycle; retire must yield
rcn_load_vld  in  1  load/exchange result valid
rcn_load_slice  in  2  owning slice of result
rcn_load_sel  in  3  destination register index
rcn_load  in  32  result data, already lane-adjusted
rf_wr  out  1  register file write strobe
rf_wr_slice  out  2  register file bank (slice)
rf_wr_sel  out  3  register index
rf_wr_data  out  32  write data
retire_stall  out  4  per-slice stall, ORed by the core with the RCN stall vector
overflow  out  1  sticky: a result was dropped into a full FIFO

Behaviour:
- Four independent FIFOs, one per slice. Each entry is {sel[2:0], data[31:0]}. Pointers are $clog2(DEPTH)+1 bits with wrap bit; full/empty come from pointer compare.
- Push: rcn_load_vld pushes into FIFO[rcn_load_slice] at the clock edge.
- Pop condition for FIFO[slice], evaluated each cycle: FIFO[slice] non-empty and !core_wb_vld. Only the FIFO matching the current slice can pop, so there is at most one pop per cycle.
- Pop output: registered. The cycle after the pop, rf_wr=1, rf_wr_slice is the popped slice, and rf_wr_sel/rf_wr_data come from the head entry. Otherwise rf_wr=0, and rf_wr_sel/rf_wr_data hold their last values.
- Latency: result arrives in cycle t. The earliest pop is cycle t+1 if slice==rcn_load_slice at t+1. rf_wr follows at t+2. Worst case without core contention is t+5.
- Simultaneous push and pop on the same FIFO is legal. The count is unchanged, and an empty FIFO is never popped in the same cycle it is pushed (no bypass, base build).
- Full FIFO receiving a push: the data is dropped, pointers are unchanged, and overflow is set to 1. overflow clears only on rst.
- core_wb_vld=1 blocks the pop. The entry waits a full rotation (4 cycles) for the next slot of its slice.
- retire_stall[s] = FIFO[s] non-empty OR (rcn_load_vld AND rcn_load_slice==s). This is combinational, so there is no gap between the RCN stall dropping and the retire stall rising.
- Reset (also mid-operation) clears all pointers, rf_wr=0, rf_wr_slice=0, rf_wr_sel=0, rf_wr_data=0, overflow=0. Buffered results are discarded. Storage arrays are not reset.

Optional Feature:
TAWAS_LOAD_RETIRE_BYPASS_EN
- When defined: if rcn_load_vld and rcn_load_slice==slice and FIFO[slice] is empty and !core_wb_vld, the result skips the FIFO. rf_wr and its fields are registered directly from the rcn_load* inputs next cycle. No push occurs, and retire_stall[slice] stays asserted that cycle only through its combinational term. Latency from arrival to rf_wr is 1 cycle.
- When undefined: the base behaviour above applies; every result is pushed.

Decomposition:
- Shared include tawas_defs.vh holds these constants: slice count (4), slice width (2), register-select width (3), data width (32).
- One natural sub-module: tawas_retire_fifo, a single-slice synchronous FIFO. Parameter DEPTH; ports push, pop, din[34:0], dout[34:0], empty, full. It is instantiated four times via generate.
- Top level contains the pop selection, output register, bypass, stall and overflow logic.

Test Plan:
- Rotating slice; load {slice=2, sel=5, data=0xDEADBEEF} arrives when slice==1 -> pop at slice==2 next cycle; rf_wr=1 one cycle later with rf_wr_slice=2, rf_wr_sel=5, rf_wr_data=0xDEADBEEF; retire_stall[2] high from arrival until the pop cycle inclusive.
- Same as above, but core_wb_vld=1 during the first slice-2 slot -> no rf_wr; write occurs 4 cycles later at the next slice-2 slot, and stall is held throughout.
- DEPTH=2: three loads to slice 0 (data 1,2,3) while slice 0 slots are blocked -> overflow=1; subsequent writes deliver 1 then 2 in order, and 3 is never written.
- Loads to slices 0,1,2,3 on consecutive cycles -> exactly four rf_wr pulses, each in its own slice slot, and the data matches the slice.
- Assert rst while FIFOs hold entries -> next cycle all outputs are 0, retire_stall=0, and no rf_wr is emitted afterwards for the discarded data.
- With TAWAS_LOAD_RETIRE_BYPASS_EN defined: load {slice=3, data=0x12345678} arrives while slice==3, FIFO empty, core_wb_vld=0 -> rf_wr=1 next cycle with that data, and FIFO[3] stays empty. Without the macro, the same write occurs at the next slice-3 slot.
